// File: rtl/seq_pkg.sv
// Shared types and constant tables for the pc_sequencer program-flow controller.
// Holds the FSM state enum, the halt opcode, the entry-point table and the jump-target table.
package seq_pkg;

  localparam int unsigned SEQ_PC_W  = 10;
  localparam int unsigned SEQ_LUT_N = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_HALT  = 2'd3
  } seq_state_e;

  localparam logic [5:0] HALT_OPC = 6'b111111;

  localparam logic [SEQ_PC_W-1:0] ENTRY [3] = '{
    10'h000, 10'h040, 10'h200
  };

  localparam logic [SEQ_PC_W-1:0] JTAB [SEQ_LUT_N] = '{
    10'h000, 10'h030, 10'h07C, 10'h100, 10'h155, 10'h1A0, 10'h200, 10'h2AA,
    10'h2F0, 10'h333, 10'h380, 10'h3C0, 10'h3F0, 10'h3FC, 10'h3FE, 10'h3FF
  };

  // Program select 3 has no table slot and falls back to entry 0.
  function automatic logic [SEQ_PC_W-1:0] entry_pc(input logic [1:0] sel);
    logic [SEQ_PC_W-1:0] pc;
    case (sel)
      2'd1:    pc = ENTRY[1];
      2'd2:    pc = ENTRY[2];
      default: pc = ENTRY[0];
    endcase
    return pc;
  endfunction

endpackage

// File: rtl/jump_lut.sv
// Combinational jump-target lookup: decoder LUT index to absolute program address.
// Kept as its own block so a loadable table can replace the constant one later.
module jump_lut
  import seq_pkg::*;
#(
  parameter int unsigned PC_W  = SEQ_PC_W,
  parameter int unsigned LUT_W = 4
) (
  input  logic [LUT_W-1:0] lut_ptr_i,
  output logic [PC_W-1:0]  target_o
);

  always_comb begin
    target_o = PC_W'(JTAB[lut_ptr_i]);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-flow controller: PC, Start/Done handshake, entry select, jumps and halt detection.
// Optional executed-cycle counter is built when CYCLE_CNT_EN is defined.
module pc_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned PC_W  = SEQ_PC_W,
  parameter int unsigned LUT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       ProgSel,
  input  logic [8:0]       Instr,
  input  logic             JmpEn,
  input  logic [LUT_W-1:0] LutPointer,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             RunEn,
  output logic             Done
`ifdef CYCLE_CNT_EN
  ,
  output logic [15:0]      CycleCnt
`endif
);

  seq_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            done_q, done_d;
  logic [PC_W-1:0] jmp_target;
  logic            is_halt;
  logic            unused_instr_low;

  assign unused_instr_low = ^Instr[2:0];
  assign is_halt          = (Instr[8:3] == HALT_OPC);

  jump_lut #(
    .PC_W  (PC_W),
    .LUT_W (LUT_W)
  ) u_jump_lut (
    .lut_ptr_i (LutPointer),
    .target_o  (jmp_target)
  );

  // Next-state, next-PC and write qualifier.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    RunEn   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        pc_d = PC_W'(entry_pc(ProgSel));
        if (!Start) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Host abort outranks halt, jump and increment.
        if (Start) begin
          state_d = ST_ARMED;
        end else if (is_halt) begin
          state_d = ST_HALT;
        end else begin
          RunEn = 1'b1;
          if (JmpEn) begin
            pc_d = jmp_target;
          end else if (&pc_q) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      ST_HALT: begin
        if (Start) state_d = ST_ARMED;
      end
      default: state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_HALT);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

  assign ProgCtr = pc_q;
  assign Done    = done_q;

`ifdef CYCLE_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counts RUN cycles (halt cycle included), saturating; cleared while armed.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_ARMED) begin
      cnt_d = '0;
    end else if (state_q == ST_RUN && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign CycleCnt = cnt_q;
`endif

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-flow controller for the 9-bit single-cycle core. Owns the program counter, runs the host Start/Done handshake, selects a program entry point, applies taken jumps from the decoder through a jump-target lookup table, and detects halt. Its outputs are the instruction-ROM address and a run-enable that gates every architectural write (register file and data memory).

## Interface
Parameters:
- PC_W, 10, program counter width; instruction ROM depth is 2**PC_W.
- LUT_W, 4, jump-LUT index width; matches the decoder's LutPointer.

Ports:
- Clk  in  1  core clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  host request; high holds the block armed, and the falling edge launches execution.
- ProgSel  in  2  program select, sampled while armed; indexes the entry-point table.
- Instr  in  9  instruction currently read from ROM at ProgCtr (combinational ROM).
- JmpEn  in  1  decoder's taken-jump indication for Instr.
- LutPointer  in  LUT_W  decoder's jump-target index.
- ProgCtr  out  PC_W  registered program counter (ROM address).
- RunEn  out  1  write qualifier for reg_wr_en/dat_wr_en; high only when executing a non-halt instruction.
- Done  out  1  registered; high while halted, awaiting the next Start.
- CycleCnt  out  16  executed-cycle count (present only with CYCLE_CNT_EN).

## Operation
States: IDLE, ARMED, RUN, HALT.
- Reset: state=IDLE, ProgCtr=0, Done=0, RunEn=0, CycleCnt=0.
- IDLE: Start=1 -> ARMED. Otherwise hold.
- ARMED: every cycle ProgCtr <= ENTRY[ProgSel] (the last ProgSel before the fall wins). Start=0 -> RUN. Done=0.
- RUN:
  - Halt is Instr[8:3]==6'b111111. Halt -> HALT, ProgCtr holds, RunEn=0 in that cycle.
  - Else if JmpEn=1: ProgCtr <= JTAB[LutPointer], which is absolute.
  - Else, if ProgCtr is all ones: -> HALT, ProgCtr holds (wrap guard, no wrap to 0), RunEn=1 for this last instruction.
  - Else ProgCtr <= ProgCtr+1, computed in PC_W bits.
  - Start=1 in RUN aborts: -> ARMED this edge, with priority over halt, jump and increment. RunEn=0 in that cycle.
- HALT: Done=1, ProgCtr frozen, RunEn=0. Start=1 -> ARMED (Done drops on the same edge).
- ProgSel value 3 with no table entry defined maps to ENTRY[0].
- Reset has priority over all transitions in every state, including mid-run.

## Timing
- ProgCtr and Done are registered; RunEn is combinational from state, Instr and Start.
- The cycle after Start falls is the first RUN cycle, and ProgCtr=ENTRY[ProgSel] in it.
- One instruction per cycle. A taken jump takes effect on the next edge, with no bubble and no delay slot.
- Done rises one cycle after the halt instruction is presented.
- Minimum host sequence: Start high for at least 1 cycle, then low. Done is valid 1 cycle after the halt cycle.

## Configuration
- CYCLE_CNT_EN defined:
  - CycleCnt increments on every RUN cycle, including the halt cycle, and saturates at 16'hFFFF.
  - It clears to 0 in ARMED and holds in HALT/IDLE.
- CYCLE_CNT_EN undefined: the CycleCnt port and its register are absent.

## Structure
- Package seq_pkg holds:
  - the state enum (IDLE, ARMED, RUN, HALT);
  - HALT_OPC = 6'b111111;
  - the ENTRY constant array (3 entries, PC_W each);
  - the JTAB constant array (16 entries, PC_W each).
- One sub-module, jump_lut: combinational JTAB lookup, LutPointer -> PC_W target. Sized for later replacement by a loadable table.

## Test plan
- Reset in RUN at ProgCtr=37:
  - next cycle state=IDLE, ProgCtr=0, Done=0, RunEn=0.
  - Start=0 afterwards keeps it idle.
- Start 1 for 3 cycles with ProgSel=1, then 0:
  - first RUN cycle ProgCtr=ENTRY[1], RunEn=1.
  - next 4 cycles ProgCtr = ENTRY[1]+1..+4.
- In RUN at ProgCtr=20 with JmpEn=1 and LutPointer=5:
  - next ProgCtr=JTAB[5].
  - JmpEn=0 the cycle after: JTAB[5]+1.
- Instr=9'h1F8 at ProgCtr=50:
  - RunEn=0 that cycle.
  - Done=1 next cycle, with ProgCtr held at 50 indefinitely.
  - Then Start pulse: Done=0 and ProgCtr=ENTRY[ProgSel].
- ProgCtr=10'h3FF, no jump or halt:
  - RunEn=1, then HALT with ProgCtr=10'h3FF, Done=1.
  - No wrap to 0.
- With CYCLE_CNT_EN, a run of 12 instructions plus halt:
  - CycleCnt=13 in HALT.
  - Restart clears it to 0 in ARMED.
